// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam int          DEFAULT_TIMEOUT       = 255;
    localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Width needed to hold 0..t, never below one bit.
    function automatic int cnt_width(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the arbiter: both master request ports plus the shared
// slave port. 'slave' is the arbiter's view (it serves the masters and
// drives the slave request); 'master' is the surrounding system's view.
interface mem_arbiter_if;

    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr,  m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;

    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    modport slave (
        input  m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wstrb, m1_wstrb, s_ready, s_rdata,
        output m0_ready, m1_ready, m0_rdata, m1_rdata,
               s_valid, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m0_valid, m1_valid, m0_addr, m1_addr, m0_wdata, m1_wdata,
               m0_wstrb, m1_wstrb, s_ready, s_rdata,
        input  m0_ready, m1_ready, m0_rdata, m1_rdata,
               s_valid, s_addr, s_wdata, s_wstrb
    );

endinterface

// File: rtl/mem_arbiter_wdt.sv
// Saturating bus watchdog counter; hit flags the forced-completion cycle.
module mem_arbiter_wdt
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] CTO  = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins; otherwise count enabled cycles and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero timeout disables the watchdog entirely.
    assign hit = (TIMEOUT != 0) && (cnt_q == CTO);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin (or fixed-priority) arbiter for the native
// valid/ready bus, with a watchdog that force-completes hung transactions.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          TIMEOUT       = DEFAULT_TIMEOUT,
    parameter logic [31:0] TIMEOUT_RDATA = DEFAULT_TIMEOUT_RDATA,
    parameter bit          PRIO_FIXED    = 1'b0
) (
    input  logic          clk,
    input  logic          resetn,
    mem_arbiter_if.slave  bus,
    input  logic          err_clr,
    output logic          timeout_err,
    output logic [31:0]   err_addr,
    output logic          err_master
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        err_master_q, err_master_d;

    logic        busy, wdt_hit, slv_done, force_done, done, winner;
    logic        own_valid;
    logic [31:0] own_addr, own_wdata, done_rdata;
    logic [3:0]  own_wstrb;

    assign busy = (state_q == ST_BUSY);

    // Select the current owner's request fields.
    always_comb begin
        own_valid = owner_q ? bus.m1_valid : bus.m0_valid;
        own_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
        own_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;
        own_wstrb = owner_q ? bus.m1_wstrb : bus.m0_wstrb;
    end

    // The watchdog counts only BUSY cycles that did not complete.
    mem_arbiter_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (!busy),
        .enable (busy && !done),
        .hit    (wdt_hit)
    );

    // The slave request is withdrawn on the forced cycle so a late s_ready
    // cannot complete, and the pending write is dropped.
    assign bus.s_valid = busy && own_valid && !wdt_hit;
    assign bus.s_addr  = busy ? own_addr  : '0;
    assign bus.s_wdata = busy ? own_wdata : '0;
    assign bus.s_wstrb = busy ? own_wstrb : '0;

    assign slv_done   = bus.s_valid && bus.s_ready;
    assign force_done = busy && own_valid && wdt_hit;
    assign done       = slv_done || force_done;
    assign done_rdata = slv_done ? bus.s_rdata : TIMEOUT_RDATA;

    assign bus.m0_ready = done && !owner_q;
    assign bus.m1_ready = done &&  owner_q;
    assign bus.m0_rdata = bus.m0_ready ? done_rdata : '0;
    assign bus.m1_rdata = bus.m1_ready ? done_rdata : '0;

    assign timeout_err = timeout_err_q;
    assign err_addr    = err_addr_q;
    assign err_master  = err_master_q;

    // Contention goes to m0 under fixed priority, else to the master that
    // did not finish last; a lone requester always wins.
    always_comb begin
        if (bus.m0_valid && bus.m1_valid) begin
            winner = PRIO_FIXED ? 1'b0 : !last_q;
        end else begin
            winner = bus.m1_valid;
        end
    end

    // Next-state logic: grant in IDLE, complete or abandon in BUSY.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        timeout_err_d = timeout_err_q;
        err_addr_d    = err_addr_q;
        err_master_d  = err_master_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    owner_d = winner;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (done) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end else if (!own_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A new forced completion takes precedence over a clear.
        if (force_done) begin
            timeout_err_d = 1'b1;
            err_addr_d    = own_addr;
            err_master_d  = owner_q;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // State and error registers; last=1 so m0 wins the first contention.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            err_addr_q    <= '0;
            err_master_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            timeout_err_q <= timeout_err_d;
            err_addr_q    <= err_addr_d;
            err_master_q  <= err_master_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: expected completions are queued as stimulus is issued
// and a monitor pops and compares on every master ready.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic        m;
        logic [31:0] rdata;
        logic [31:0] saddr;
        logic        chk_saddr;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        err_clr;
    logic        timeout_err, err_master;
    logic [31:0] err_addr;
    logic        fx_timeout_err, fx_err_master;
    logic [31:0] fx_err_addr;

    int vectors    = 0;
    int miscompares = 0;

    exp_t expq[$];
    req_t rq0[$], rq1[$];

    int slave_wait = 0;
    bit silent     = 1'b0;
    int wcnt       = 0;

    mem_arbiter_if bus ();
    mem_arbiter_if bus_fx ();

    mem_arbiter #(.TIMEOUT(4), .TIMEOUT_RDATA(32'hDEAD_BEEF), .PRIO_FIXED(1'b0)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .err_addr    (err_addr),
        .err_master  (err_master)
    );

    mem_arbiter #(.TIMEOUT(4), .TIMEOUT_RDATA(32'hDEAD_BEEF), .PRIO_FIXED(1'b1)) dut_fx (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus_fx),
        .err_clr     (1'b0),
        .timeout_err (fx_timeout_err),
        .err_addr    (fx_err_addr),
        .err_master  (fx_err_master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    function automatic logic [31:0] srd(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A);
    endfunction

    // Slave model for the round-robin DUT: answers after slave_wait cycles.
    always @(negedge clk) begin
        if (bus.s_valid && !bus.s_ready && !silent) begin
            if (wcnt >= slave_wait) begin
                bus.s_ready = 1'b1;
                bus.s_rdata = srd(bus.s_addr);
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            bus.s_ready = 1'b0;
            bus.s_rdata = '0;
            wcnt = 0;
        end
    end

    // Zero-wait slave for the fixed-priority DUT.
    always @(negedge clk) begin
        bus_fx.s_ready = bus_fx.s_valid;
        bus_fx.s_rdata = bus_fx.s_addr;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready must match the head of the scoreboard.
    exp_t        mon_e;
    logic        mon_m;
    logic [31:0] mon_rd, mon_other;
    always begin
        @(negedge clk);
        #2;
        if (bus.m0_ready || bus.m1_ready) begin
            vectors++;
            if (bus.m0_ready && bus.m1_ready) begin
                miscompares++;
                $display("FAIL mon_both_ready: both masters ready at %0t", $time);
            end else if (expq.size() == 0) begin
                miscompares++;
                $display("FAIL mon_unexpected: ready m1=%b with empty scoreboard at %0t",
                         bus.m1_ready, $time);
            end else begin
                mon_e     = expq.pop_front();
                mon_m     = bus.m1_ready;
                mon_rd    = mon_m ? bus.m1_rdata : bus.m0_rdata;
                mon_other = mon_m ? bus.m0_rdata : bus.m1_rdata;
                if (mon_m !== mon_e.m || mon_rd !== mon_e.rdata || mon_other !== 32'h0 ||
                    (mon_e.chk_saddr ? (bus.s_valid !== 1'b1 || bus.s_addr !== mon_e.saddr)
                                     : (bus.s_valid !== 1'b0))) begin
                    miscompares++;
                    $display("FAIL mon_resp: got m=%0d rdata=%h other=%h s_valid=%b s_addr=%h expected m=%0d rdata=%h s_addr=%h",
                             mon_m, mon_rd, mon_other, bus.s_valid, bus.s_addr,
                             mon_e.m, mon_e.rdata, mon_e.saddr);
                end
            end
        end
    end

    task automatic set_m(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            bus.m0_valid = v; bus.m0_addr = a; bus.m0_wdata = d; bus.m0_wstrb = s;
        end else begin
            bus.m1_valid = v; bus.m1_addr = a; bus.m1_wdata = d; bus.m1_wstrb = s;
        end
    endtask

    // Present each queued request and hold it until that master's ready.
    task automatic drive(input int m);
        req_t r;
        int   budget;
        logic rdy;
        while ((m == 0 ? rq0.size() : rq1.size()) > 0) begin
            r = (m == 0) ? rq0.pop_front() : rq1.pop_front();
            set_m(m, 1'b1, r.addr, r.wdata, r.wstrb);
            budget = 0;
            do begin
                @(negedge clk);
                #2;
                rdy = (m == 0) ? bus.m0_ready : bus.m1_ready;
                budget++;
            end while (!rdy && budget < 100);
            if (!rdy) begin
                vectors++;
                miscompares++;
                $display("FAIL drive_m%0d_wait: no ready for addr %h within 100 cycles", m, r.addr);
            end
            @(posedge clk);
            #1;
            set_m(m, 1'b0, '0, '0, '0);
        end
    endtask

    initial begin
        int   cyc, svc, m0cnt;
        bit   seen;
        exp_t e;
        resetn  = 1'b0;
        err_clr = 1'b0;
        set_m(0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, '0, '0, '0);
        bus_fx.m0_valid = 1'b0; bus_fx.m0_addr = '0; bus_fx.m0_wdata = '0; bus_fx.m0_wstrb = '0;
        bus_fx.m1_valid = 1'b0; bus_fx.m1_addr = '0; bus_fx.m1_wdata = '0; bus_fx.m1_wstrb = '0;

        // Reset state.
        #13;
        chk1 ("rst_m0_ready", bus.m0_ready, 1'b0);
        chk1 ("rst_m1_ready", bus.m1_ready, 1'b0);
        chk1 ("rst_s_valid",  bus.s_valid,  1'b0);
        chk32("rst_s_addr",   bus.s_addr,   32'h0);
        chk32("rst_s_wdata",  bus.s_wdata,  32'h0);
        chk1 ("rst_timeout_err", timeout_err, 1'b0);
        chk32("rst_err_addr", err_addr, 32'h0);
        chk1 ("rst_err_master", err_master, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Contention, 1-wait slave: grants alternate starting with m0.
        slave_wait = 1;
        for (int i = 0; i < 3; i++) begin
            rq0.push_back('{addr: 32'h1000_0000 + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
            rq1.push_back('{addr: 32'h2000_0000 + 32'(4 * i), wdata: 32'h0, wstrb: 4'h0});
        end
        expq.push_back('{m: 1'b0, rdata: 32'h4A5A_5A5A, saddr: 32'h1000_0000, chk_saddr: 1'b1});
        expq.push_back('{m: 1'b1, rdata: 32'h7A5A_5A5A, saddr: 32'h2000_0000, chk_saddr: 1'b1});
        expq.push_back('{m: 1'b0, rdata: 32'h4A5A_5A5E, saddr: 32'h1000_0004, chk_saddr: 1'b1});
        expq.push_back('{m: 1'b1, rdata: 32'h7A5A_5A5E, saddr: 32'h2000_0004, chk_saddr: 1'b1});
        expq.push_back('{m: 1'b0, rdata: 32'h4A5A_5A52, saddr: 32'h1000_0008, chk_saddr: 1'b1});
        expq.push_back('{m: 1'b1, rdata: 32'h7A5A_5A52, saddr: 32'h2000_0008, chk_saddr: 1'b1});
        fork
            drive(0);
            drive(1);
        join
        @(posedge clk);
        #1;

        // Lone m0 read, zero-wait slave: s_valid and ready in cycle 1.
        slave_wait = 0;
        expq.push_back('{m: 1'b0, rdata: 32'h1234_5678, saddr: 32'h0000_0010, chk_saddr: 1'b1});
        set_m(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
        @(negedge clk); #2;
        chk1("p1_cyc0_s_valid", bus.s_valid, 1'b0);
        @(negedge clk); #2;
        chk1("p1_cyc1_s_valid", bus.s_valid, 1'b1);
        chk1("p1_cyc1_m0_ready", bus.m0_ready, 1'b1);
        chk1("p1_cyc1_m1_ready", bus.m1_ready, 1'b0);
        @(posedge clk); #1;
        set_m(0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;

        // Watchdog: m1 write, silent slave, TIMEOUT=4.
        silent = 1'b1;
        expq.push_back('{m: 1'b1, rdata: 32'hDEAD_BEEF, saddr: 32'h0, chk_saddr: 1'b0});
        set_m(1, 1'b1, 32'h0300_0000, 32'hCAFE_F00D, 4'hF);
        cyc = 0; svc = 0;
        do begin
            @(negedge clk); #2;
            if (cyc == 1) chk32("wdt_s_wdata", bus.s_wdata, 32'hCAFE_F00D);
            if (bus.s_valid) svc++;
            if (bus.m1_ready) break;
            cyc++;
        end while (cyc < 20);
        chk32("wdt_ready_cycle", 32'(cyc), 32'd5);
        chk32("wdt_s_valid_cycles", 32'(svc), 32'd4);
        @(posedge clk); #1;
        set_m(1, 1'b0, '0, '0, '0);
        chk1 ("wdt_timeout_err", timeout_err, 1'b1);
        chk32("wdt_err_addr", err_addr, 32'h0300_0000);
        chk1 ("wdt_err_master", err_master, 1'b1);

        // err_clr coinciding with a new forced completion: set wins.
        expq.push_back('{m: 1'b0, rdata: 32'hDEAD_BEEF, saddr: 32'h0, chk_saddr: 1'b0});
        set_m(0, 1'b1, 32'h0400_0000, 32'h0, 4'h0);
        cyc = 0;
        do begin
            @(negedge clk); #2;
            cyc++;
        end while (!bus.m0_ready && cyc < 20);
        chk1("clr_force_seen", bus.m0_ready, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        set_m(0, 1'b0, '0, '0, '0);
        chk1 ("clr_same_cycle_err", timeout_err, 1'b1);
        chk1 ("clr_err_master", err_master, 1'b0);
        chk32("clr_err_addr", err_addr, 32'h0400_0000);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk1("clr_lone", timeout_err, 1'b0);

        // Async reset in BUSY: outputs drop at once, no ready pulse.
        set_m(0, 1'b1, 32'h0500_0000, 32'h0, 4'h0);
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk1("rb_busy_s_valid", bus.s_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk1 ("rb_s_valid", bus.s_valid, 1'b0);
        chk32("rb_s_addr", bus.s_addr, 32'h0);
        chk1 ("rb_m0_ready", bus.m0_ready, 1'b0);
        chk32("rb_err_addr", err_addr, 32'h0);
        set_m(0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        silent = 1'b0;
        @(posedge clk); #1;
        expq.push_back('{m: 1'b1, rdata: 32'h5C5A_5A5A, saddr: 32'h0600_0000, chk_saddr: 1'b1});
        set_m(1, 1'b1, 32'h0600_0000, 32'h0, 4'h0);
        @(negedge clk); #2;
        chk1("ra_cyc0_s_valid", bus.s_valid, 1'b0);
        @(negedge clk); #2;
        chk1("ra_cyc1_s_valid", bus.s_valid, 1'b1);
        chk1("ra_cyc1_m1_ready", bus.m1_ready, 1'b1);
        @(posedge clk); #1;
        set_m(1, 1'b0, '0, '0, '0);

        // Fixed priority: m1 starves while m0 keeps requesting.
        bus_fx.m0_valid = 1'b1; bus_fx.m0_addr = 32'h0000_0100;
        bus_fx.m1_valid = 1'b1; bus_fx.m1_addr = 32'h0000_0200;
        m0cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #2;
            chk1("fx_m1_blocked", bus_fx.m1_ready, 1'b0);
            if (bus_fx.m0_ready) m0cnt++;
        end
        chk32("fx_m0_grants", 32'(m0cnt), 32'd10);
        @(posedge clk); #1;
        bus_fx.m0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); #2;
            if (bus_fx.m1_ready) seen = 1'b1;
        end
        chk1("fx_m1_after_release", seen, 1'b1);
        @(posedge clk); #1;
        bus_fx.m1_valid = 1'b0;
        chk1 ("fx_no_timeout", fx_timeout_err, 1'b0);
        chk32("fx_err_addr", fx_err_addr, 32'h0);
        chk1 ("fx_err_master", fx_err_master, 1'b0);

        @(posedge clk); #1;
        chk32("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter for the native valid/ready memory bus of the SoC. It shares one slave-side bus port (RAM, flash controller, IO decode) between the CPU (m0) and a second requester such as a DMA engine (m1). Grants are round-robin and held for a whole transaction. A bus watchdog completes any transaction the slave leaves hanging, so a missing peripheral cannot lock up the CPU.

## Interface
Parameters:
- `TIMEOUT`, 255: BUSY cycles allowed before forced completion. Range 0..65535; 0 disables the watchdog.
- `TIMEOUT_RDATA`, 32'hDEAD_BEEF: read data returned on a forced completion.
- `PRIO_FIXED`, 0: when 1, m0 always wins contention; when 0, round-robin.

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_valid`, `m1_valid`  in  1  master request; held high until that master's ready.
- `m0_addr`, `m1_addr`  in  32  address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 means read.
- `m0_ready`, `m1_ready`  out  1  single-cycle completion.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid only with ready.
- `s_valid`  out  1  slave request.
- `s_addr`  out  32  slave address.
- `s_wdata`  out  32  slave write data.
- `s_wstrb`  out  4  slave byte strobes.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data.
- `err_clr`  in  1  clears `timeout_err`.
- `timeout_err`  out  1  sticky; set by any forced completion.
- `err_addr`  out  32  address of the most recent forced completion.
- `err_master`  out  1  master of the most recent forced completion.

## Operation
- States: IDLE, BUSY. Registers: `owner`, `last`, `cnt`, plus the error registers.
- Reset values:
  - state IDLE, `owner`=0, `last`=1 (so m0 wins first), `cnt`=0.
  - `timeout_err`=0, `err_addr`=0, `err_master`=0.
  - Every output low or zero.
- IDLE:
  - If any valid is high, choose the winner, register `owner`, clear `cnt`, go to BUSY.
  - Single requester wins.
  - On contention with round-robin, the master other than `last` wins. With `PRIO_FIXED`, m0 wins.
- BUSY:
  - `s_valid` = owner's valid && !`wdt_hit`.
  - `s_addr`/`s_wdata`/`s_wstrb` mux from the owner. They are 0 in IDLE.
- Slave completion: when `s_ready`=1 and `s_valid`=1:
  - Owner's ready=1 and owner's rdata=`s_rdata`, combinational in the same cycle.
  - Update `last`=owner and go to IDLE.
- Non-owner: ready=0 and rdata=0 at all times.
- Watchdog:
  - `cnt` increments each BUSY cycle without completion and saturates.
  - `wdt_hit` = (`TIMEOUT`!=0) && (`cnt`==`TIMEOUT`).
  - On `wdt_hit`: owner's ready=1, rdata=`TIMEOUT_RDATA`, and the write is dropped.
  - Same cycle: set `timeout_err`; latch `err_addr`=owner address and `err_master`=owner.
  - Update `last` and go to IDLE.
- `s_ready` while `s_valid`=0 is ignored.
- Owner drops valid in BUSY (protocol violation): return to IDLE, no ready, no error.
- `err_clr` clears `timeout_err`. A set in the same cycle wins.
- `cnt` width: ceil(log2(`TIMEOUT`+1)), minimum 1.

## Timing
- Arbitration costs one cycle:
  - Master valid first seen in cycle 0.
  - `s_valid` high in cycle 1.
  - With a zero-wait slave, master ready in cycle 1.
- Back-to-back transactions: cycle after completion is IDLE. Each grant therefore has at least one cycle of gap.
- Contention, both valid continuously: grants alternate m0, m1, m0, ... Each master waits at most one foreign transaction.
- Forced completion:
  - `s_valid` is high exactly `TIMEOUT` cycles (grant cycle 1 .. `TIMEOUT`).
  - Master ready comes in cycle `TIMEOUT`+1.
- Async reset mid-BUSY: outputs drop immediately, with no ready pulse. After release, operation starts from IDLE.

## Structure
- Package `mem_arbiter_pkg`:
  - state enum.
  - `DEFAULT_TIMEOUT`.
  - `DEFAULT_TIMEOUT_RDATA`.
- One sub-module, `mem_arbiter_wdt`:
  - ports: clear, enable, `hit`.
  - parameterised counter, saturating.
- Grant logic and muxing stay in the top level.

## Test plan
- m0 read 0x0000_0010 alone, slave ready in the same cycle with rdata 0x1234_5678:
  - `s_valid` in cycle 1.
  - `m0_ready` in cycle 1 with `m0_rdata`=0x1234_5678.
  - `m1_ready` stays 0.
- Both masters valid continuously for 6 transactions, 1-wait slave:
  - grant order m0, m1, m0, m1, m0, m1.
  - `s_addr` matches the owner each time.
- `PRIO_FIXED`=1, both valid continuously: m1 never granted while m0 is requesting.
- `TIMEOUT`=4, m1 write to 0x0300_0000, slave silent:
  - `s_valid` high for 4 cycles.
  - `m1_ready` in cycle 5.
  - `timeout_err`=1, `err_addr`=0x0300_0000, `err_master`=1.
- `err_clr` pulsed in the same cycle as a new forced completion: `timeout_err` stays 1. A later lone `err_clr` clears it to 0.
- `resetn` asserted during BUSY:
  - all outputs 0 immediately.
  - after release, m1 alone requests: granted in cycle 1 and completes normally.
